// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// The serial adder reuses the state enum defined here.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } serial_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Valid/ready operand and result channels of the serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bout
  );
endinterface

// File: rtl/fullsubtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, bout is the borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, LSB first, one cell and a borrow flop.
// Handshake flags are flops that mirror the state, so no input reaches them combinationally.
import serial_pkg::*;

module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);
  localparam int unsigned     CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  serial_state_t    state;
  serial_state_t    state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             cell_d;
  logic             cell_br;
  logic             accept;
  logic             last_bit;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  fullsubtractor u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow),
    .diff (cell_d),
    .bout (cell_br)
  );

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign res_next = WIDTH'({cell_d, res_sh} >> 1);
  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_bit = (state == BUSY) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = BUSY;
      BUSY:    if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  // Operand/result shifters, bit counter, borrow flop and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res_sh <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      cnt    <= cnt + CW'(1);
      borrow <= cell_br;
      if (last_bit) begin
        diff_q <= res_next;
        bout_q <= cell_br;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor at WIDTH=4 and WIDTH=1.
module tb_serial_subtractor;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();

  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [3:0] av, input logic [3:0] bv,
                        input logic ordy);
    if (w == 4) begin
      if4.in_valid = v; if4.a = av; if4.b = bv; if4.out_ready = ordy;
    end else begin
      if1.in_valid = v; if1.a = av[0]; if1.b = bv[0]; if1.out_ready = ordy;
    end
  endtask

  function automatic logic f_rdy(input int w);
    return (w == 4) ? if4.in_ready : if1.in_ready;
  endfunction
  function automatic logic f_vld(input int w);
    return (w == 4) ? if4.out_valid : if1.out_valid;
  endfunction
  function automatic logic [3:0] f_diff(input int w);
    return (w == 4) ? if4.diff : {3'b000, if1.diff};
  endfunction
  function automatic logic f_bout(input int w);
    return (w == 4) ? if4.bout : if1.bout;
  endfunction

  // Full transaction: accept, latency, result, optional back-pressure, release.
  task automatic op(input int w, input logic [3:0] av, input logic [3:0] bv,
                    input int stall, input string tag);
    logic [4:0] r4;
    logic [1:0] r1;
    logic [3:0] ed;
    logic       eb;
    int         lat;
    r4 = {1'b0, av} - {1'b0, bv};
    r1 = {1'b0, av[0]} - {1'b0, bv[0]};
    ed = (w == 4) ? r4[3:0] : {3'b000, r1[0]};
    eb = (w == 4) ? r4[4] : r1[1];
    check({tag, "/idle_rdy"}, 32'(f_rdy(w)), 32'd1);
    set_in(w, 1'b1, av, bv, stall == 0);
    @(negedge clk);
    set_in(w, 1'b0, 4'h0, 4'h0, stall == 0);
    check({tag, "/busy_rdy"}, 32'(f_rdy(w)), 32'd0);
    lat = 0;
    while (!f_vld(w) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(w));
    check({tag, "/diff"}, 32'(f_diff(w)), 32'(ed));
    check({tag, "/bout"}, 32'(f_bout(w)), 32'(eb));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "/hold_vld"}, 32'(f_vld(w)), 32'd1);
      check({tag, "/hold_rdy"}, 32'(f_rdy(w)), 32'd0);
      check({tag, "/hold_diff"}, 32'(f_diff(w)), 32'(ed));
      check({tag, "/hold_bout"}, 32'(f_bout(w)), 32'(eb));
    end
    set_in(w, 1'b0, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    check({tag, "/rel_vld"}, 32'(f_vld(w)), 32'd0);
    check({tag, "/rel_rdy"}, 32'(f_rdy(w)), 32'd1);
  endtask

  initial begin
    int  lat;
    logic saw;
    set_in(4, 1'b0, 4'h0, 4'h0, 1'b1);
    set_in(1, 1'b0, 4'h0, 4'h0, 1'b1);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst/in_ready", 32'(if4.in_ready), 32'd1);
    check("rst/out_valid", 32'(if4.out_valid), 32'd0);
    check("rst/diff", 32'(if4.diff), 32'd0);
    check("rst/bout", 32'(if4.bout), 32'd0);
    check("rst/in_ready_w1", 32'(if1.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(4, 4'd9, 4'd3, 0, "basic_9_3");
    op(4, 4'd3, 4'd9, 0, "under_3_9");
    op(4, 4'd0, 4'd1, 0, "under_0_1");
    op(4, 4'd0, 4'd0, 0, "zero_0_0");
    op(4, 4'd12, 4'd4, 5, "bp_12_4");

    // Reset two cycles into BUSY: outputs clear at once and no result follows.
    set_in(4, 1'b1, 4'd9, 4'd3, 1'b1);
    @(negedge clk);
    set_in(4, 1'b0, 4'h0, 4'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/in_ready", 32'(if4.in_ready), 32'd1);
    check("midrst/out_valid", 32'(if4.out_valid), 32'd0);
    check("midrst/diff", 32'(if4.diff), 32'd0);
    check("midrst/bout", 32'(if4.bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      saw = saw | if4.out_valid;
    end
    check("midrst/no_valid", 32'(saw), 32'd0);
    check("midrst/idle_rdy", 32'(if4.in_ready), 32'd1);

    // Operands offered during BUSY/DONE are taken only after the return to IDLE.
    set_in(4, 1'b1, 4'd12, 4'd5, 1'b1);
    @(negedge clk);
    set_in(4, 1'b1, 4'd15, 4'd15, 1'b1);
    check("ign/busy_rdy", 32'(if4.in_ready), 32'd0);
    lat = 0;
    while (!if4.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign/latency", 32'(lat), 32'd4);
    check("ign/diff", 32'(if4.diff), 32'd7);
    check("ign/bout", 32'(if4.bout), 32'd0);
    @(negedge clk);
    check("ign/rel_vld", 32'(if4.out_valid), 32'd0);
    check("ign/rel_rdy", 32'(if4.in_ready), 32'd1);
    @(negedge clk);
    set_in(4, 1'b0, 4'h0, 4'h0, 1'b1);
    check("ign/acc2_rdy", 32'(if4.in_ready), 32'd0);
    lat = 0;
    while (!if4.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ign/latency2", 32'(lat), 32'd4);
    check("ign/diff2", 32'(if4.diff), 32'd0);
    check("ign/bout2", 32'(if4.bout), 32'd0);
    @(negedge clk);
    check("ign/rel2_rdy", 32'(if4.in_ready), 32'd1);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        op(4, 4'(ia), 4'(ib), int'($urandom_range(0, 2)), "sweep4");
    for (int ia = 0; ia < 2; ia++)
      for (int ib = 0; ib < 2; ib++)
        op(1, 4'(ia), 4'(ib), int'($urandom_range(0, 2)), "sweep1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
